// File: rtl/fifo_pkg.sv
// Shared constants, read-port mode type and clog2 helper for the FIFO slice.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;

    typedef enum logic {
        RD_REGISTERED = 1'b0,
        RD_COMBINATIONAL = 1'b1
    } rd_mode_e;

    function automatic int clog2(input int value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v = (value > 1) ? int'(value - 1) : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return int'(result);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_param.
interface sync_fifo_param_if import fifo_pkg::*; #(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) ();
    localparam int ADDR_W = clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_dpram.sv
// DATA_W x DEPTH dual-port RAM: synchronous write, registered or combinational read.
module fifo_dpram import fifo_pkg::*; #(
    parameter int       DATA_W  = FIFO_DATA_W_DEF,
    parameter int       DEPTH   = FIFO_DEPTH_DEF,
    parameter rd_mode_e RD_MODE = RD_REGISTERED
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      re,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]         rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset; the empty flag guards reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (RD_MODE == RD_REGISTERED) begin : g_rd_reg
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata <= '0;
            end else if (re) begin
                rdata <= mem[raddr];
            end
        end
    end else begin : g_rd_comb
        assign rdata = mem[raddr];
    end
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised circular-buffer FIFO with thresholds, occupancy and error pulses.
// Define FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_param import fifo_pkg::*; #(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input logic              clk,
    input logic              reset,
    sync_fifo_param_if.slave bus
);
    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

`ifdef FIFO_FWFT_EN
    localparam rd_mode_e RD_MODE = RD_COMBINATIONAL;
`else
    localparam rd_mode_e RD_MODE = RD_REGISTERED;
`endif

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full_c;
    logic              empty_c;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        empty_c = (count_q == '0);
        wr_acc  = bus.wr_en & ~full_c;
        rd_acc  = bus.rd_en & ~empty_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= bus.wr_en & full_c;
            underflow_q <= bus.rd_en & empty_c;
        end
    end

    fifo_dpram #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RD_MODE (RD_MODE)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

`ifdef FIFO_FWFT_EN
    assign bus.dout_valid = ~empty_c;
`else
    logic dout_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_acc;
        end
    end

    assign bus.dout_valid = dout_valid_q;
`endif

    assign bus.dout         = rdata;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (16x8 defaults).
module tb_sync_fifo_param;
    logic clk;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

    sync_fifo_param #(
        .DATA_W    (8),
        .DEPTH     (16),
        .AF_THRESH (14),
        .AE_THRESH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_write(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            bus.wr_en = 1'b1;
            bus.din   = base + 8'(i);
            exp_q.push_back(bus.din);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

`ifndef FIFO_FWFT_EN
    task automatic do_read(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_en = 1'b1;
            tick();
            exp_v = exp_q.pop_front();
            check("drain_dout", bus.dout, exp_v);
            check("drain_valid", bus.dout_valid, 1);
        end
        bus.rd_en = 1'b0;
    endtask
`endif

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_aempty", bus.almost_empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_afull", bus.almost_full, 0);
        check("rst_valid", bus.dout_valid, 0);

`ifndef FIFO_FWFT_EN
        check("rst_dout", bus.dout, 0);

        // Fill 0x01..0x10, tracking the threshold flags word by word.
        for (int i = 1; i <= 16; i++) begin
            bus.wr_en = 1'b1;
            bus.din   = 8'(i);
            tick();
            check("fill_count", bus.count, i);
            check("fill_afull", bus.almost_full, (i >= 14) ? 1 : 0);
            check("fill_aempty", bus.almost_empty, (i <= 2) ? 1 : 0);
        end
        check("fill_full", bus.full, 1);
        bus.din = 8'hAA;
        tick();
        check("ovf_pulse", bus.overflow, 1);
        check("ovf_count", bus.count, 16);
        bus.wr_en = 1'b0;
        tick();
        check("ovf_clear", bus.overflow, 0);

        for (int i = 1; i <= 16; i++) begin
            bus.rd_en = 1'b1;
            tick();
            check("rd_dout", bus.dout, i);
            check("rd_valid", bus.dout_valid, 1);
            check("rd_count", bus.count, 16 - i);
        end
        check("rd_empty", bus.empty, 1);
        tick();
        check("unf_pulse", bus.underflow, 1);
        check("unf_dout_hold", bus.dout, 8'h10);
        check("unf_valid", bus.dout_valid, 0);
        bus.rd_en = 1'b0;
        tick();
        check("unf_clear", bus.underflow, 0);

        // Pointer wrap: 10 in, 8 out, 12 in, then drain.
        do_write(10, 8'h20);
        do_read(8);
        do_write(12, 8'h40);
        check("wrap_count", bus.count, 14);
        do_read(14);
        check("wrap_end_count", bus.count, 0);

        do_write(5, 8'h60);
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1;
            bus.rd_en = 1'b1;
            bus.din   = 8'h70 + 8'(i);
            exp_q.push_back(bus.din);
            tick();
            exp_v = exp_q.pop_front();
            check("simul_count", bus.count, 5);
            check("simul_dout", bus.dout, exp_v);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        do_read(5);
        check("simul_end_count", bus.count, 0);

        do_write(16, 8'h80);
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 8'hEE;
        tick();
        exp_v = exp_q.pop_front();
        check("fullrw_dout", bus.dout, exp_v);
        check("fullrw_ovf", bus.overflow, 1);
        check("fullrw_count", bus.count, 15);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        do_read(15);

        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.din   = 8'h99;
        tick();
        check("emptyrw_unf", bus.underflow, 1);
        check("emptyrw_count", bus.count, 1);
        check("emptyrw_valid", bus.dout_valid, 0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        exp_q.push_back(8'h99);

        do_write(6, 8'hC0);
        check("prerst_count", bus.count, 7);
        reset     = 1'b1;
        bus.wr_en = 1'b1;
        bus.din   = 8'hBB;
        tick();
        check("midrst_count", bus.count, 0);
        check("midrst_empty", bus.empty, 1);
        check("midrst_dout", bus.dout, 0);
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        exp_q.delete();
        bus.rd_en = 1'b1;
        tick();
        check("midrst_nowrite", bus.underflow, 1);
        bus.rd_en = 1'b0;
        tick();
`else
        bus.wr_en = 1'b1;
        bus.din   = 8'h5A;
        tick();
        bus.din   = 8'h5B;
        check("fwft_dout", bus.dout, 8'h5A);
        check("fwft_valid", bus.dout_valid, 1);
        check("fwft_count", bus.count, 1);
        tick();
        bus.wr_en = 1'b0;
        check("fwft_head_hold", bus.dout, 8'h5A);
        bus.rd_en = 1'b1;
        tick();
        check("fwft_pop_dout", bus.dout, 8'h5B);
        check("fwft_pop_count", bus.count, 1);
        tick();
        bus.rd_en = 1'b0;
        check("fwft_empty", bus.empty, 1);
        check("fwft_invalid", bus.dout_valid, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next-generation replacement for the 16x8 shift-register FIFO.
- Circular buffer with separate read/write pointers, so a read no longer shifts memory.
- Supports a same-cycle read and write, almost-full/almost-empty thresholds, an occupancy count and overflow/underflow error pulses.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_W, 8: data width in bits.
- DEPTH, 16: number of entries; must be a power of 2 and ≥ 2.
- AF_THRESH, 14: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH.
- ADDR_W (localparam), clog2(DEPTH): pointer width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- din  input  DATA_W  write data.
- rd_en  input  1  read request.
- dout  output  DATA_W  read data.
- dout_valid  output  1  dout carries newly read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_THRESH.
- almost_empty  output  1  count ≤ AE_THRESH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - Flags: empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not cleared; reading before any write is impossible because empty is 1.
- Reset priority: reset overrides wr_en/rd_en in the same cycle. A reset mid-operation discards all contents and any in-flight read.
- Accept rules, evaluated on the state before the edge:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
- Write: on wr_acc, mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH, wrapping naturally at ADDR_W bits.
- Read, standard mode:
  - On rd_acc, dout <= mem[rd_ptr], rd_ptr increments modulo DEPTH, and dout_valid = 1 in the next cycle.
  - Read latency is 1 cycle.
  - Without rd_acc, dout holds its last value and dout_valid = 0.
- Count update:
  - wr_acc only: count + 1.
  - rd_acc only: count − 1.
  - Both or neither: count unchanged.
- Simultaneous read and write:
  - At 0 < count < DEPTH, both are accepted and count is unchanged.
  - When full, the write is rejected even if a read is accepted that cycle.
  - When empty, the read is rejected even if a write is accepted; the written word becomes readable next cycle.
- Error pulses:
  - overflow = 1 for the cycle after wr_en & full.
  - underflow = 1 for the cycle after rd_en & empty.
  - Rejected operations do not change pointers, count or memory.
- Flag timing: full, empty, almost_full and almost_empty are combinational decodes of registered count, so they are valid in the same cycle count changes.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - dout = mem[rd_ptr] combinationally and dout_valid = !empty.
  - rd_en acts as the acknowledge that pops the head.
  - Read latency is 0; the head word appears one cycle after the write into an empty FIFO.
- Undefined: the standard registered 1-cycle read described in Behaviour.
- All other ports and rules are identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2 constant function;
  - default constants FIFO_DATA_W_DEF = 8 and FIFO_DEPTH_DEF = 16.
- One sub-module, fifo_dpram (DATA_W x DEPTH):
  - synchronous write;
  - read port selectable registered or combinational, so the FWFT build reuses it.
- Pointer, count and flag logic stay in sync_fifo_param.

Test Plan:
- Reset then idle: count=0, empty=1, almost_empty=1, full=0, dout=0, dout_valid=0.
- Write 0x01..0x10 (16 words, default parameters):
  - almost_full first asserts after the 14th write;
  - full=1 and count=16 after the 16th;
  - a 17th write of 0xAA gives overflow=1 for one cycle and count stays 16.
- Read 16 from full: dout sequence 0x01..0x10, each 1 cycle after rd_en with dout_valid=1; then empty=1, and one extra rd_en gives underflow=1 with dout held at 0x10.
- Wrap-around and simultaneous access:
  - write 10, read 8, write 12 to force pointer wrap, then drain: order preserved and count ends at 0;
  - at count=5, drive wr_en=rd_en=1 for 4 cycles: count stays 5 and data order is preserved.
- Full/empty corner cases:
  - at full with wr_en=rd_en=1: read accepted, write rejected, overflow=1, count=15;
  - at empty with both asserted: write accepted, underflow=1, count=1.
- Reset mid-operation and FWFT build:
  - assert reset at count=7 alongside wr_en: next cycle count=0, empty=1, no write;
  - with FIFO_FWFT_EN defined, write 0x5A into the empty FIFO: dout=0x5A and dout_valid=1 the following cycle without rd_en.
